doodle_motion_ctrl: RTL and testbench

Frame-rate motion sequencer for the doodle-jump game. Once per displayed frame it advances the doodle's vertical jump/fall physics, decides when the playfield must scroll instead of the doodle rising, and detects game over. It drives the vertical doodle position and platform scroll offset consumed by the VGA renderer, and takes platform-landing information back from the collision logic.

---
 rtl/doodle_motion_ctrl.sv | 153 +++++++++++++++
 tb/tb_doodle_motion_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/doodle_motion_ctrl.sv
// Per-frame vertical motion sequencer for the doodle: jump/fall physics,
// scroll hand-off above the scroll line, and game-over detection.
module doodle_motion_ctrl #(
    parameter int unsigned START_Y       = 400,
    parameter int unsigned JUMP_V        = 12,
    parameter int unsigned GRAVITY       = 1,
    parameter int unsigned MAX_FALL      = 12,
    parameter int unsigned SCROLL_LINE   = 200,
    parameter int unsigned SCREEN_BOTTOM = 515
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        on_platform,
    output logic [9:0]  doodle_y,
    output logic [9:0]  scroll_offset,
    output logic [15:0] score,
    output logic        falling,
    output logic        game_over,
    output logic        update_done
);

    localparam logic [10:0] START_W  = 11'(START_Y);
    localparam logic [10:0] SCROLL_W = 11'(SCROLL_LINE);
    localparam logic [10:0] BOTTOM_W = 11'(SCREEN_BOTTOM);
    localparam logic [5:0]  JUMP_W   = 6'(JUMP_V);
    localparam logic [5:0]  GRAV_W   = 6'(GRAVITY);
    localparam logic [5:0]  MAXF_W   = 6'(MAX_FALL);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RISE,
        S_FALL,
        S_OVER
    } state_e;

    state_e      state_q, state_d;
    logic [9:0]  y_q, y_d;
    logic [5:0]  vel_q, vel_d;
    logic [9:0]  off_q, off_d;
    logic [15:0] score_q, score_d;
    logic        done_q, done_d;
    logic        falling_q, over_q;

    logic [10:0] y_up, y_dn, excess;
    logic [16:0] score_sum;
    logic [6:0]  vel_inc;
    logic        stays_below_line;

    // 11-bit intermediates: bit 10 of y_up flags an underflow past row 0
    always_comb begin
        y_up             = {1'b0, y_q} - {5'd0, vel_q};
        y_dn             = {1'b0, y_q} + {5'd0, vel_q};
        stays_below_line = !y_up[10] && (y_up >= SCROLL_W);
        excess           = SCROLL_W - y_up;
        score_sum        = {1'b0, score_q} + {6'd0, excess};
        vel_inc          = {1'b0, vel_q} + {1'b0, GRAV_W};
    end

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        vel_d   = vel_q;
        off_d   = off_q;
        score_d = score_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                y_d   = START_W[9:0];
                vel_d = 6'd0;
                if (start) begin
                    state_d = S_RISE;
                    vel_d   = JUMP_W;
                    off_d   = 10'd0;
                    score_d = 16'd0;
                end
            end
            S_RISE: begin
                if (frame_tick) begin
                    done_d = 1'b1;
                    if (stays_below_line) begin
                        y_d = y_up[9:0];
                    end else begin
                        y_d     = SCROLL_W[9:0];
                        off_d   = off_q + excess[9:0];
                        score_d = score_sum[16] ? 16'hFFFF
                                                : score_sum[15:0];
                    end
                    if (vel_q <= GRAV_W) begin
                        state_d = S_FALL;
                        vel_d   = 6'd0;
                    end else begin
                        vel_d = vel_q - GRAV_W;
                    end
                end
            end
            S_FALL: begin
                if (frame_tick) begin
                    done_d = 1'b1;
                    if (on_platform) begin
                        state_d = S_RISE;
                        vel_d   = JUMP_W;
                    end else if (y_dn > BOTTOM_W) begin
                        state_d = S_OVER;
                        y_d     = BOTTOM_W[9:0];
                    end else begin
                        y_d   = y_dn[9:0];
                        vel_d = (vel_inc > {1'b0, MAXF_W}) ? MAXF_W
                                                           : vel_inc[5:0];
                    end
                end
            end
            S_OVER: begin
                if (start) begin
                    state_d = S_IDLE;
                    y_d     = START_W[9:0];
                    vel_d   = 6'd0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            y_q       <= START_W[9:0];
            vel_q     <= 6'd0;
            off_q     <= 10'd0;
            score_q   <= 16'd0;
            done_q    <= 1'b0;
            falling_q <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            y_q       <= y_d;
            vel_q     <= vel_d;
            off_q     <= off_d;
            score_q   <= score_d;
            done_q    <= done_d;
            falling_q <= (state_d == S_FALL);
            over_q    <= (state_d == S_OVER);
        end
    end

    assign doodle_y      = y_q;
    assign scroll_offset = off_q;
    assign score         = score_q;
    assign falling       = falling_q;
    assign game_over     = over_q;
    assign update_done   = done_q;

endmodule

// File: tb/tb_doodle_motion_ctrl.sv
// Bench for doodle_motion_ctrl: directed vectors, corner sequences and
// randomized play against an integer reference model.
module tb_doodle_motion_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Two instances: default geometry (a) and a low scroll line (b)
    logic        a_rst_n, a_start, a_tick, a_onp;
    logic [9:0]  a_y, a_off;
    logic [15:0] a_score;
    logic        a_fall, a_over, a_done;
    logic        b_rst_n, b_start, b_tick, b_onp;
    logic [9:0]  b_y, b_off;
    logic [15:0] b_score;
    logic        b_fall, b_over, b_done;

    doodle_motion_ctrl u_a (
        .clk(clk), .rst_n(a_rst_n), .frame_tick(a_tick), .start(a_start),
        .on_platform(a_onp), .doodle_y(a_y), .scroll_offset(a_off),
        .score(a_score), .falling(a_fall), .game_over(a_over),
        .update_done(a_done)
    );

    doodle_motion_ctrl #(.SCROLL_LINE(380)) u_b (
        .clk(clk), .rst_n(b_rst_n), .frame_tick(b_tick), .start(b_start),
        .on_platform(b_onp), .doodle_y(b_y), .scroll_offset(b_off),
        .score(b_score), .falling(b_fall), .game_over(b_over),
        .update_done(b_done)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: game state kept as plain integers
    typedef struct {
        int st;   // 0 idle, 1 rise, 2 fall, 3 over
        int y;
        int vel;
        int off;
        int score;
        int done;
    } mdl_t;

    function automatic mdl_t mdl_step(mdl_t m, int sl, bit rst_n,
                                      bit start, bit tick, bit onp);
        mdl_t r = m;
        int ny;
        r.done = 0;
        if (!rst_n) begin
            r = '{0, 400, 0, 0, 0, 0};
        end else if (m.st == 0) begin
            r.y = 400;
            r.vel = 0;
            if (start) begin
                r.st = 1; r.vel = 12; r.off = 0; r.score = 0;
            end
        end else if (m.st == 1 && tick) begin
            r.done = 1;
            ny = m.y - m.vel;
            if (ny >= sl) r.y = ny;
            else begin
                r.y = sl;
                r.off = (m.off + (sl - ny)) % 1024;
                r.score = m.score + (sl - ny);
                if (r.score > 65535) r.score = 65535;
            end
            if (m.vel <= 1) begin r.st = 2; r.vel = 0; end
            else r.vel = m.vel - 1;
        end else if (m.st == 2 && tick) begin
            r.done = 1;
            if (onp) begin r.st = 1; r.vel = 12; end
            else if (m.y + m.vel > 515) begin r.y = 515; r.st = 3; end
            else begin
                r.y = m.y + m.vel;
                r.vel = (m.vel + 1 > 12) ? 12 : m.vel + 1;
            end
        end else if (m.st == 3 && start) begin
            r.st = 0; r.y = 400; r.vel = 0;
        end
        return r;
    endfunction

    mdl_t ma, mb;

    task automatic cyc_a(input bit r, input bit s, input bit t, input bit p);
        a_rst_n = r; a_start = s; a_tick = t; a_onp = p;
        @(posedge clk);
        ma = mdl_step(ma, 200, r, s, t, p);
        #1;
    endtask

    task automatic cyc_b(input bit r, input bit s, input bit t, input bit p);
        b_rst_n = r; b_start = s; b_tick = t; b_onp = p;
        @(posedge clk);
        mb = mdl_step(mb, 380, r, s, t, p);
        #1;
    endtask

    task automatic cmp_a();
        bit ok;
        checks++;
        ok = (a_y == 10'(ma.y)) && (a_off == 10'(ma.off)) &&
             (a_score == 16'(ma.score)) && (a_fall == (ma.st == 2)) &&
             (a_over == (ma.st == 3)) && (a_done == ma.done[0]);
        if (!ok) begin
            failures++;
            $display("FAIL model_a: got y=%0d off=%0d sc=%0d f=%0d o=%0d d=%0d expected y=%0d off=%0d sc=%0d st=%0d d=%0d",
                     a_y, a_off, a_score, a_fall, a_over, a_done,
                     ma.y, ma.off, ma.score, ma.st, ma.done);
        end
    endtask

    task automatic cmp_b();
        bit ok;
        checks++;
        ok = (b_y == 10'(mb.y)) && (b_off == 10'(mb.off)) &&
             (b_score == 16'(mb.score)) && (b_fall == (mb.st == 2)) &&
             (b_over == (mb.st == 3)) && (b_done == mb.done[0]);
        if (!ok) begin
            failures++;
            $display("FAIL model_b: got y=%0d off=%0d sc=%0d f=%0d o=%0d d=%0d expected y=%0d off=%0d sc=%0d st=%0d d=%0d",
                     b_y, b_off, b_score, b_fall, b_over, b_done,
                     mb.y, mb.off, mb.score, mb.st, mb.done);
        end
    endtask

    typedef struct {
        bit rst_n, start, tick, onp;
        int y;
        bit fall, over, done;
    } vec_t;

    vec_t tv[19];
    int   rise_y[12] = '{388, 377, 367, 358, 350, 343,
                         337, 332, 328, 325, 323, 322};

    initial begin
        int n;
        bit wrapped;
        a_rst_n = 0; a_start = 0; a_tick = 0; a_onp = 0;
        b_rst_n = 0; b_start = 0; b_tick = 0; b_onp = 0;
        ma = '{0, 400, 0, 0, 0, 0};
        mb = '{0, 400, 0, 0, 0, 0};

        tv[0] = '{0, 0, 0, 0, 400, 0, 0, 0};
        tv[1] = '{1, 1, 1, 0, 400, 0, 0, 0};
        for (int i = 0; i < 12; i++)
            tv[2 + i] = '{1, 0, 1, 0, rise_y[i], i == 11, 0, 1};
        tv[14] = '{1, 0, 0, 1, 322, 1, 0, 0};
        tv[15] = '{1, 0, 1, 1, 322, 0, 0, 1};
        tv[16] = '{1, 0, 1, 0, 310, 0, 0, 1};
        tv[17] = '{1, 1, 1, 0, 299, 0, 0, 1};
        tv[18] = '{0, 1, 1, 0, 400, 0, 0, 0};

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 19; i++) begin
            cyc_a(tv[i].rst_n, tv[i].start, tv[i].tick, tv[i].onp);
            chk($sformatf("vec%0d_y", i), a_y, tv[i].y);
            chk($sformatf("vec%0d_fall", i), a_fall, tv[i].fall);
            chk($sformatf("vec%0d_over", i), a_over, tv[i].over);
            chk($sformatf("vec%0d_done", i), a_done, tv[i].done);
            chk($sformatf("vec%0d_off", i), a_off, 0);
        end

        // Fall from the apex to the bottom of the screen
        cyc_a(1, 1, 0, 0);
        n = 0;
        while (!a_over && n < 200) begin
            cyc_a(1, 0, 1, 0);
            n++;
        end
        chk("over_reached", a_over, 1);
        chk("over_clamp_y", a_y, 515);
        repeat (3) begin
            cyc_a(1, 0, 1, 1);
            chk("over_no_done", a_done, 0);
            chk("over_frozen_y", a_y, 515);
        end
        cyc_a(1, 1, 0, 0);
        chk("restart_y", a_y, 400);
        chk("restart_over", a_over, 0);

        // Low scroll line: rise turns into scroll
        cyc_b(0, 0, 0, 0);
        cyc_b(1, 1, 0, 0);
        cyc_b(1, 0, 1, 0);
        chk("scr_y1", b_y, 388);
        chk("scr_off1", b_off, 0);
        cyc_b(1, 0, 1, 0);
        chk("scr_y2", b_y, 380);
        chk("scr_off2", b_off, 3);
        cyc_b(1, 0, 1, 0);
        chk("scr_y3", b_y, 380);
        chk("scr_off3", b_off, 13);
        chk("scr_score3", b_score, 13);

        // Endless bouncing on back-to-back ticks until score saturates
        wrapped = 0;
        for (int i = 0; i < 12000; i++) begin
            cyc_b(1, 0, 1, mb.st == 2);
            cmp_b();
            if (mb.off < 20 && mb.score > 20) wrapped = 1;
        end
        chk("score_saturated", b_score, 65535);
        chk("offset_wrapped", int'(wrapped), 1);

        // Randomized play on both instances against the model
        cyc_a(0, 0, 0, 0);
        cmp_a();
        for (int i = 0; i < 4000; i++) begin
            cyc_a($urandom_range(0, 199) != 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
            cmp_a();
        end
        cyc_b(0, 0, 0, 0);
        cmp_b();
        for (int i = 0; i < 4000; i++) begin
            cyc_b($urandom_range(0, 199) != 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
            cmp_b();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
